// File: rtl/timer_reg_arbiter.sv
// Two-requester arbiter in front of the timer register port.
// Round-robin grant with optional lock; each transfer is a strobe cycle followed by a response cycle.
module timer_reg_arbiter #(
  parameter int unsigned BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [3:0]           addr0,
  input  logic [3:0]           addr1,
  input  logic [BIT_WIDTH-1:0] wdata0,
  input  logic [BIT_WIDTH-1:0] wdata1,
  input  logic                 lock0,
  input  logic                 lock1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 err0,
  output logic                 err1,
  output logic [BIT_WIDTH-1:0] rdata0,
  output logic [BIT_WIDTH-1:0] rdata1,
  output logic                 tmr_en,
  output logic                 tmr_we,
  output logic [3:0]           tmr_addr,
  output logic [BIT_WIDTH-1:0] tmr_wdata,
  input  logic [BIT_WIDTH-1:0] tmr_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, LOCKED} state_t;

  localparam logic [3:0] LAST_ADDR = 4'hB;

  state_t               state;
  logic                 owner;
  logic                 last_grant;
  logic                 grant_valid;
  logic                 grant_sel;
  logic                 sel_we;
  logic [3:0]           sel_addr;
  logic [BIT_WIDTH-1:0] sel_wdata;
  logic                 owner_lock;
  logic                 bad_addr;

  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    case (state)
      IDLE: begin
        grant_valid = req0 | req1;
        grant_sel   = (req0 & req1) ? ~last_grant : req1;
      end
      LOCKED: begin
        grant_valid = owner ? req1 : req0;
        grant_sel   = owner;
      end
      default: ;
    endcase
  end

  assign sel_we     = grant_sel ? we1    : we0;
  assign sel_addr   = grant_sel ? addr1  : addr0;
  assign sel_wdata  = grant_sel ? wdata1 : wdata0;
  assign owner_lock = owner ? lock1 : lock0;
  // The tmr_* fields double as the latched transfer, so they hold between strobes.
  assign bad_addr   = tmr_addr > LAST_ADDR;

  // Read data passes straight through in the response cycle, gated by the registered ack.
  assign rdata0 = (ack0 && !tmr_we && !err0) ? tmr_rdata : '0;
  assign rdata1 = (ack1 && !tmr_we && !err1) ? tmr_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      tmr_en     <= 1'b0;
      tmr_we     <= 1'b0;
      tmr_addr   <= '0;
      tmr_wdata  <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
    end else begin
      tmr_en <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      case (state)
        IDLE, LOCKED: begin
          if (grant_valid) begin
            owner      <= grant_sel;
            last_grant <= grant_sel;
            tmr_we     <= sel_we;
            tmr_addr   <= sel_addr;
            tmr_wdata  <= sel_wdata;
            tmr_en     <= (sel_addr <= LAST_ADDR);
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          ack0  <= ~owner;
          ack1  <= owner;
          err0  <= ~owner & bad_addr;
          err1  <= owner & bad_addr;
          state <= RESP;
        end
        RESP: begin
          state <= owner_lock ? LOCKED : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_timer_reg_arbiter.sv
// Bench for timer_reg_arbiter: directed vector table, multi-cycle sequences,
// then random traffic against a transaction-level reference model.
module tb_timer_reg_arbiter;
  localparam int unsigned BW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [3:0]    addr0, addr1;
  logic [BW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err0, err1;
  logic [BW-1:0] rdata0, rdata1;
  logic          tmr_en, tmr_we;
  logic [3:0]    tmr_addr;
  logic [BW-1:0] tmr_wdata, tmr_rdata;

  timer_reg_arbiter #(.BIT_WIDTH(BW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .tmr_en(tmr_en), .tmr_we(tmr_we), .tmr_addr(tmr_addr),
    .tmr_wdata(tmr_wdata), .tmr_rdata(tmr_rdata)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ack0"},      32'(ack0),      32'd0);
    check({tag, " ack1"},      32'(ack1),      32'd0);
    check({tag, " err0"},      32'(err0),      32'd0);
    check({tag, " err1"},      32'(err1),      32'd0);
    check({tag, " rdata0"},    32'(rdata0),    32'd0);
    check({tag, " rdata1"},    32'(rdata1),    32'd0);
    check({tag, " tmr_en"},    32'(tmr_en),    32'd0);
    check({tag, " tmr_we"},    32'(tmr_we),    32'd0);
    check({tag, " tmr_addr"},  32'(tmr_addr),  32'd0);
    check({tag, " tmr_wdata"}, 32'(tmr_wdata), 32'd0);
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    lock0 = 1'b0; lock1 = 1'b0;
  endtask

  typedef struct {
    logic          r0, r1, w0, w1;
    logic [3:0]    a0, a1;
    logic [BW-1:0] d0, d1, trd;
    logic          own, en, err;
    logic [BW-1:0] rd;
  } vec_t;
  vec_t vecs [7];

  // Reference model state (transaction level)
  int unsigned   m_phase;
  logic          m_owner, m_last, m_locked;
  logic          t_we;
  logic [3:0]    t_addr;
  logic [BW-1:0] t_wdata;
  logic [BW-1:0] mem   [16];
  logic [BW-1:0] tregs [16];
  logic          e_ack [2];
  logic          e_err [2];
  logic [BW-1:0] e_rdata [2];
  logic          e_en, e_we;
  logic [3:0]    e_addr;
  logic [BW-1:0] e_wdata;
  logic          r_act [2];
  logic          r_we [2];
  logic          r_lock [2];
  logic [3:0]    r_addr [2];
  logic [BW-1:0] r_wdata [2];
  logic          ack_now [2];
  logic          s_en, s_we;
  logic [3:0]    s_addr;
  logic [BW-1:0] s_wdata;
  logic          g_ok, g_sel;

  int ack_who [4];
  int ack_at  [4];
  int n_acks, viol, a_seen0, r0st, first_at, first_own;
  logic got0, got1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h4, 4'h0, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h8, 8'h00, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 4'h2, 8'h00, 8'h00, 8'h77, 1'b1, 1'b1, 1'b0, 8'h77};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'hB, 4'h3, 8'h11, 8'h22, 8'h99, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'hC, 8'h00, 8'hFF, 8'h44, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};

    reset = 1'b1;
    idle_inputs();
    tmr_rdata = 8'hC7;
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Single transfers from idle; round-robin state carries across vectors.
    for (int v = 0; v < 7; v++) begin
      @(posedge clk); #1;
      req0 = vecs[v].r0; req1 = vecs[v].r1; we0 = vecs[v].w0; we1 = vecs[v].w1;
      addr0 = vecs[v].a0; addr1 = vecs[v].a1; wdata0 = vecs[v].d0; wdata1 = vecs[v].d1;
      lock0 = 1'b0; lock1 = 1'b0; tmr_rdata = vecs[v].trd;
      @(negedge clk);
      @(negedge clk);
      check($sformatf("vec%0d strobe tmr_en", v), 32'(tmr_en), 32'(vecs[v].en));
      if (vecs[v].en) begin
        check($sformatf("vec%0d tmr_addr", v), 32'(tmr_addr),
              32'(vecs[v].own ? vecs[v].a1 : vecs[v].a0));
        check($sformatf("vec%0d tmr_wdata", v), 32'(tmr_wdata),
              32'(vecs[v].own ? vecs[v].d1 : vecs[v].d0));
        check($sformatf("vec%0d tmr_we", v), 32'(tmr_we),
              32'(vecs[v].own ? vecs[v].w1 : vecs[v].w0));
      end
      check($sformatf("vec%0d early ack", v), 32'(ack0 | ack1), 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d ack0", v), 32'(ack0), 32'(!vecs[v].own));
      check($sformatf("vec%0d ack1", v), 32'(ack1), 32'(vecs[v].own));
      check($sformatf("vec%0d err", v), 32'(vecs[v].own ? err1 : err0), 32'(vecs[v].err));
      check($sformatf("vec%0d rdata", v), 32'(vecs[v].own ? rdata1 : rdata0), 32'(vecs[v].rd));
      check($sformatf("vec%0d resp tmr_en", v), 32'(tmr_en), 32'd0);
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d ack after resp", v), 32'(ack0 | ack1), 32'd0);
    end

    // Contention from reset: both read continuously.
    @(posedge clk); #1;
    reset = 1'b1;
    idle_inputs();
    req0 = 1'b1; req1 = 1'b1; addr0 = 4'h8; addr1 = 4'h9;
    tmr_rdata = 8'h3C;
    @(posedge clk); #1;
    reset = 1'b0;
    n_acks = 0;
    for (int k = 0; k < 4; k++) begin ack_who[k] = -1; ack_at[k] = -1; end
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (ack0 && n_acks < 4) begin ack_who[n_acks] = 0; ack_at[n_acks] = n; n_acks++; end
      if (ack1 && n_acks < 4) begin ack_who[n_acks] = 1; ack_at[n_acks] = n; n_acks++; end
    end
    check("contention ack count", 32'(n_acks), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("contention owner %0d", k), 32'(ack_who[k]), 32'(k % 2));
      check($sformatf("contention cycle %0d", k), 32'(ack_at[k]), 32'(3 + 3 * k));
    end

    // Lock: requester 0 keeps ownership across two writes while requester 1 waits.
    @(posedge clk); #1;
    reset = 1'b1;
    idle_inputs();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h8; wdata0 = 8'hA1; lock0 = 1'b1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'h5; wdata1 = 8'hB2; lock1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    n_acks = 0; viol = 0; a_seen0 = 0; r0st = 0;
    for (int k = 0; k < 4; k++) ack_who[k] = -1;
    for (int c = 0; c < 20 && n_acks < 3; c++) begin
      @(negedge clk);
      if (tmr_en && tmr_addr == 4'h5 && a_seen0 < 2) viol++;
      got0 = ack0; got1 = ack1;
      if (got0 && n_acks < 4) begin ack_who[n_acks] = 0; n_acks++; end
      if (got0) a_seen0++;
      if (got1 && n_acks < 4) begin ack_who[n_acks] = 1; n_acks++; end
      @(posedge clk); #1;
      if (got1) req1 = 1'b0;
      case (r0st)
        0: if (got0) begin req0 = 1'b0; r0st = 1; end
        1: begin req0 = 1'b1; addr0 = 4'h9; wdata0 = 8'hC3; lock0 = 1'b0; r0st = 2; end
        2: if (got0) begin req0 = 1'b0; r0st = 3; end
        default: ;
      endcase
    end
    check("lock ack count", 32'(n_acks), 32'd3);
    check("lock first ack", 32'(ack_who[0]), 32'd0);
    check("lock second ack", 32'(ack_who[1]), 32'd0);
    check("lock third ack", 32'(ack_who[2]), 32'd1);
    check("lock foreign strobe", 32'(viol), 32'd0);
    idle_inputs();

    // Reset during ACCESS: requester 0 owns the aborted transfer and must win again.
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 4'h3; req1 = 1'b1; addr1 = 4'h7; tmr_rdata = 8'h6E;
    @(negedge clk);
    @(negedge clk);
    check("abort strobe tmr_en", 32'(tmr_en), 32'd1);
    check("abort strobe tmr_addr", 32'(tmr_addr), 32'h3);
    reset = 1'b1;
    #1;
    check_all_zero("abort reset");
    @(posedge clk); #1;
    reset = 1'b0;
    first_at = -1; first_own = -1;
    for (int n = 1; n <= 8 && first_at < 0; n++) begin
      @(negedge clk);
      if (ack0 || ack1) begin first_at = n; first_own = ack1 ? 1 : 0; end
    end
    check("abort rearb owner", 32'(first_own), 32'd0);
    check("abort rearb cycle", 32'(first_at), 32'd3);

    // Random traffic against the reference model.
    @(posedge clk); #1;
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 16; i++) begin mem[i] = '0; tregs[i] = '0; end
    for (int i = 0; i < 2; i++) begin
      r_act[i] = 1'b0; r_we[i] = 1'b0; r_lock[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
      e_ack[i] = 1'b0; e_err[i] = 1'b0; e_rdata[i] = '0; ack_now[i] = 1'b0;
    end
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    t_we = 1'b0; t_addr = '0; t_wdata = '0;
    m_phase = 0; m_last = 1'b1; m_locked = 1'b0; m_owner = 1'b0;
    s_en = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    tmr_rdata = BW'($urandom);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      check("rnd ack0", 32'(ack0), 32'(e_ack[0]));
      check("rnd ack1", 32'(ack1), 32'(e_ack[1]));
      check("rnd err0", 32'(err0), 32'(e_err[0]));
      check("rnd err1", 32'(err1), 32'(e_err[1]));
      check("rnd rdata0", 32'(rdata0), 32'(e_rdata[0]));
      check("rnd rdata1", 32'(rdata1), 32'(e_rdata[1]));
      check("rnd tmr_en", 32'(tmr_en), 32'(e_en));
      check("rnd tmr_we", 32'(tmr_we), 32'(e_we));
      check("rnd tmr_addr", 32'(tmr_addr), 32'(e_addr));
      check("rnd tmr_wdata", 32'(tmr_wdata), 32'(e_wdata));
      s_en = tmr_en; s_we = tmr_we; s_addr = tmr_addr; s_wdata = tmr_wdata;
      ack_now[0] = e_ack[0]; ack_now[1] = e_ack[1];

      // Predict next cycle's outputs from the current requests.
      for (int i = 0; i < 2; i++) begin e_ack[i] = 1'b0; e_err[i] = 1'b0; e_rdata[i] = '0; end
      e_en = 1'b0;
      case (m_phase)
        0: begin
          g_ok = 1'b0; g_sel = 1'b0;
          if (m_locked) begin
            g_sel = m_owner; g_ok = r_act[m_owner];
          end else if (r_act[0] && r_act[1]) begin
            g_ok = 1'b1; g_sel = ~m_last;
          end else if (r_act[0] || r_act[1]) begin
            g_ok = 1'b1; g_sel = r_act[1];
          end
          if (g_ok) begin
            m_owner = g_sel; m_last = g_sel;
            t_we = r_we[g_sel]; t_addr = r_addr[g_sel]; t_wdata = r_wdata[g_sel];
            e_en = (t_addr < 4'd12); e_we = t_we; e_addr = t_addr; e_wdata = t_wdata;
            m_phase = 1;
          end
        end
        1: begin
          e_ack[m_owner] = 1'b1;
          e_err[m_owner] = (t_addr >= 4'd12);
          if (t_addr < 4'd12) begin
            if (t_we) mem[t_addr] = t_wdata;
            else e_rdata[m_owner] = mem[t_addr];
          end
          m_phase = 2;
        end
        default: begin
          m_locked = r_lock[m_owner];
          m_phase = 0;
        end
      endcase

      @(posedge clk); #1;
      if (s_en && s_we) tregs[s_addr] = s_wdata;
      if (s_en && !s_we) tmr_rdata = tregs[s_addr];
      else tmr_rdata = BW'($urandom);
      for (int i = 0; i < 2; i++) begin
        if (ack_now[i]) r_act[i] = 1'b0;
        else if (!r_act[i] && $urandom_range(0, 2) == 0) begin
          r_act[i]   = 1'b1;
          r_we[i]    = 1'($urandom_range(0, 1));
          r_addr[i]  = 4'($urandom_range(0, 15));
          r_wdata[i] = BW'($urandom);
          r_lock[i]  = ($urandom_range(0, 3) == 0);
        end
      end
      req0 = r_act[0]; we0 = r_we[0]; addr0 = r_addr[0]; wdata0 = r_wdata[0]; lock0 = r_lock[0];
      req1 = r_act[1]; we1 = r_we[1]; addr1 = r_addr[1]; wdata1 = r_wdata[1]; lock1 = r_lock[1];
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
